ram_lsu: RTL and testbench

//  Initiator side of the byte-enable RAM port: load/store unit between the core data request bus and a

---
 rtl/ram_lsu_pkg.sv | 25 ++
 rtl/ram_lsu_align.sv | 48 ++++
 rtl/ram_lsu.sv | 122 ++++++++++++
 tb/tb_ram_lsu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_lsu_pkg.sv
// ram_lsu shared types: access sizes,
// FSM states and the latched request.
package ram_lsu_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE,
    RD_WAIT,
    RESP
  } state_e;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] off;
    logic       err;
  } req_t;

endpackage

// File: rtl/ram_lsu_align.sv
// Byte-lane steering: store lane enables and
// replication, load lane extraction and extension.
module ram_lsu_align
  import ram_lsu_pkg::*;
(
  input  logic [1:0]  st_size_i,
  input  logic [1:0]  st_off_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  st_wen_o,
  output logic [31:0] st_din_o,
  input  logic [1:0]  ld_size_i,
  input  logic [1:0]  ld_off_i,
  input  logic        ld_uns_i,
  input  logic [31:0] ld_dout_i,
  output logic [31:0] ld_data_o
);

  logic [31:0] sh;

  always_comb begin
    st_wen_o = 4'hF;
    st_din_o = st_wdata_i;
    unique case (1'b1)
      st_size_i == SZ_B: begin
        st_wen_o = 4'b0001 << st_off_i;
        st_din_o = {4{st_wdata_i[7:0]}};
      end
      st_size_i == SZ_H: begin
        st_wen_o = 4'b0011 << st_off_i;
        st_din_o = {2{st_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sh = ld_dout_i >> {ld_off_i, 3'b000};
    ld_data_o = sh;
    unique case (1'b1)
      ld_size_i == SZ_B:
        ld_data_o = {{24{~ld_uns_i & sh[7]}}, sh[7:0]};
      ld_size_i == SZ_H:
        ld_data_o = {{16{~ld_uns_i & sh[15]}}, sh[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_lsu.sv
// Load/store unit in front of a word-wide RAM
// with byte enables and a 1-cycle read.
module ram_lsu
  import ram_lsu_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] ram_waddr,
  output logic [3:0]    ram_wen,
  output logic [31:0]   ram_din,
  output logic          ram_ren,
  output logic [AW-1:0] ram_raddr,
  input  logic [31:0]   ram_dout
);

  state_e      state_q, state_d;
  req_t        req_q, req_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic        rsp_err_q, rsp_err_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        accept, err, ld_go;
  logic [3:0]  wen;
  logic [31:0] din, ld_data;

  // Gate with rst_n so no request is taken while in reset.
  assign req_ready = rst_n & ((state_q == IDLE) |
                     ((state_q == RESP) & rsp_ready));
  assign accept = req_valid & req_ready;

  assign err = (req_size == 2'd3)
             | ((req_size == SZ_H) & req_addr[0])
             | ((req_size == SZ_W) & (req_addr[1:0] != 2'b00))
             | (req_addr[31:AW+2] != '0);

  assign ld_go     = accept & ~req_we & ~err;
  assign ram_waddr = req_addr[AW+1:2];
  assign ram_raddr = req_addr[AW+1:2];
  assign ram_wen   = (accept & req_we & ~err) ? wen : 4'h0;
  assign ram_din   = din;
  assign ram_ren   = ld_go;

  ram_lsu_align u_align (
    .st_size_i  (req_size),
    .st_off_i   (req_addr[1:0]),
    .st_wdata_i (req_wdata),
    .st_wen_o   (wen),
    .st_din_o   (din),
    .ld_size_i  (req_q.size),
    .ld_off_i   (req_q.off),
    .ld_uns_i   (req_q.uns),
    .ld_dout_i  (ram_dout),
    .ld_data_o  (ld_data)
  );

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      RD_WAIT: begin
        state_d     = RESP;
        rsp_valid_d = 1'b1;
        rsp_err_d   = req_q.err;
        rsp_rdata_d = req_q.we ? '0 : ld_data;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: ;
    endcase
    // A new accept overrides the retire of the old response.
    if (accept) begin
      req_d = '{we: req_we, size: req_size,
                uns: req_unsigned,
                off: req_addr[1:0], err: err};
      state_d     = ld_go ? RD_WAIT : RESP;
      rsp_valid_d = ~ld_go;
      rsp_err_d   = err;
      rsp_rdata_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_ram_lsu.sv
// Self-checking bench for ram_lsu: directed table,
// random traffic vs. a byte-level memory model, corner sequences.
module tb_ram_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic [7:0]  ram_waddr, ram_raddr;
  logic [3:0]  ram_wen;
  logic [31:0] ram_din, ram_dout;
  logic        ram_ren;

  always #5 clk = ~clk;

  ram_lsu #(.DEPTH(256)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .ram_waddr(ram_waddr), .ram_wen(ram_wen),
    .ram_din(ram_din), .ram_ren(ram_ren),
    .ram_raddr(ram_raddr), .ram_dout(ram_dout)
  );

  // RAM attached to the DUT, driven only by its strobes
  logic [31:0] mem [0:255];
  logic        mem_clr;
  int          wen_pulses = 0;
  always @(posedge clk) begin
    if (ram_wen != 4'h0) wen_pulses <= wen_pulses + 1;
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (ram_ren) ram_dout <= mem[ram_raddr];
      for (int i = 0; i < 4; i++)
        if (ram_wen[i]) mem[ram_waddr][8*i +: 8] <= ram_din[8*i +: 8];
    end
  end

  // Reference: byte-addressed memory updated from request semantics
  logic [7:0] ref_mem [0:1023];
  int tests = 0;
  int fails = 0;
  int exp_pulses = 0;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a;
    logic [31:0] wd;
    logic        e;
    logic [3:0]  wen;
    logic [31:0] din;
    logic [31:0] rd;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] sz,
      input logic un, input logic [31:0] a, input logic [31:0] wd,
      input logic e, input logic [3:0] wen, input logic [31:0] din,
      input logic [31:0] rd);
    vec_t v;
    v.we = we; v.sz = sz; v.un = un; v.a = a; v.wd = wd;
    v.e = e; v.wen = wen; v.din = din; v.rd = rd;
    return v;
  endfunction

  function automatic vec_t model(input logic we, input logic [1:0] sz,
      input logic un, input logic [31:0] a, input logic [31:0] wd);
    vec_t v;
    int nb, off;
    longint val;
    v.we = we; v.sz = sz; v.un = un; v.a = a; v.wd = wd;
    v.wen = '0; v.din = '0; v.rd = '0;
    nb = 1 << sz;
    off = int'(a % 4);
    if (sz == 2'd3) v.e = 1'b1;
    else v.e = ((a % nb) != 0) || (a >= 32'd1024);
    if (!v.e && we) begin
      for (int i = 0; i < 4; i++) begin
        v.wen[i] = (i >= off) && (i < off + nb);
        v.din[8*i +: 8] = wd[8*(i % nb) +: 8];
      end
    end else if (!v.e) begin
      val = 0;
      for (int i = 0; i < nb; i++)
        val = val + (longint'(ref_mem[a + i]) << (8 * i));
      if (!un && nb < 4 && val >= (longint'(1) << (8 * nb - 1)))
        val = val - (longint'(1) << (8 * nb));
      v.rd = val[31:0];
    end
    return v;
  endfunction

  task automatic apply(input vec_t v);
    int n;
    bit ok_st, ok_ld;
    ok_st = v.we && !v.e;
    ok_ld = !v.we && !v.e;
    @(negedge clk);
    req_valid = 1'b1; req_we = v.we; req_size = v.sz;
    req_unsigned = v.un; req_addr = v.a; req_wdata = v.wd;
    rsp_ready = 1'b1;
    #1;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("req_ready", 32'(req_ready), 32'd1);
    chk("ram_wen", 32'(ram_wen), ok_st ? 32'(v.wen) : 32'd0);
    chk("ram_ren", 32'(ram_ren), 32'(ok_ld));
    if (ok_st) begin
      chk("ram_din", ram_din, v.din);
      chk("ram_waddr", 32'(ram_waddr), 32'(v.a[9:2]));
    end
    if (ok_ld) chk("ram_raddr", 32'(ram_raddr), 32'(v.a[9:2]));
    @(posedge clk); #1;
    req_valid = 1'b0;
    if (ok_ld) begin
      chk("rsp_valid_T1", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_err", 32'(rsp_err), 32'(v.e));
    chk("rsp_rdata", rsp_rdata, v.rd);
    if (ok_st) begin
      exp_pulses++;
      for (int i = 0; i < (1 << v.sz); i++)
        ref_mem[v.a + i] = v.wd[8*i +: 8];
    end
  endtask

  vec_t tbl [18];
  vec_t v;
  logic [31:0] exp_rd;
  int p0;
  logic [1:0] sz;
  logic [31:0] a;

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = '0;
    tbl[0]  = mk(1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 4'hF, 32'hDEADBEEF, 0);
    tbl[1]  = mk(0, 2, 0, 32'h10, 0, 0, 0, 0, 32'hDEADBEEF);
    tbl[2]  = mk(1, 0, 0, 32'h13, 32'h000000A5, 0, 4'h8, 32'hA5A5A5A5, 0);
    tbl[3]  = mk(0, 0, 0, 32'h13, 0, 0, 0, 0, 32'hFFFFFFA5);
    tbl[4]  = mk(0, 0, 1, 32'h13, 0, 0, 0, 0, 32'h000000A5);
    tbl[5]  = mk(0, 2, 0, 32'h10, 0, 0, 0, 0, 32'hA5ADBEEF);
    tbl[6]  = mk(1, 1, 0, 32'h22, 32'h00008001, 0, 4'hC, 32'h80018001, 0);
    tbl[7]  = mk(0, 1, 0, 32'h22, 0, 0, 0, 0, 32'hFFFF8001);
    tbl[8]  = mk(0, 1, 1, 32'h22, 0, 0, 0, 0, 32'h00008001);
    tbl[9]  = mk(0, 2, 0, 32'h20, 0, 0, 0, 0, 32'h80010000);
    tbl[10] = mk(0, 1, 0, 32'h21, 0, 1, 0, 0, 0);
    tbl[11] = mk(1, 2, 0, 32'h12, 32'h11111111, 1, 0, 0, 0);
    tbl[12] = mk(0, 3, 0, 32'h00, 0, 1, 0, 0, 0);
    tbl[13] = mk(0, 2, 0, 32'h400, 0, 1, 0, 0, 0);
    tbl[14] = mk(1, 0, 0, 32'h3FF, 32'h0000005A, 0, 4'h8, 32'h5A5A5A5A, 0);
    tbl[15] = mk(0, 0, 1, 32'h3FF, 0, 0, 0, 0, 32'h0000005A);
    tbl[16] = mk(1, 1, 0, 32'h3FE, 32'h0000BEEF, 0, 4'hC, 32'hBEEFBEEF, 0);
    tbl[17] = mk(0, 2, 0, 32'h3FC, 0, 0, 0, 0, 32'hBEEF0000);

    // Reset state with a request pending
    rst_n = 1'b0; mem_clr = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'hFFFFFFFF;
    rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_rdata", rsp_rdata, 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_ram_wen", 32'(ram_wen), 32'd0);
    chk("rst_ram_ren", 32'(ram_ren), 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_clr = 1'b0; req_valid = 1'b0;

    foreach (tbl[i]) apply(tbl[i]);

    // Back-pressure on a load with a store waiting behind it
    @(negedge clk); req_valid = 1'b0; rsp_ready = 1'b1;
    exp_rd = model(0, 2, 0, 32'h10, 0).rd;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
    req_addr = 32'h10; rsp_ready = 1'b0;
    #1; chk("bp_accept", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); #1;
      chk("bp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rdata", rsp_rdata, exp_rd);
      chk("bp_ready", 32'(req_ready), 32'd0);
      chk("bp_wen", 32'(ram_wen), 32'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1; p0 = wen_pulses;
    #1;
    chk("bp_st_ready", 32'(req_ready), 32'd1);
    chk("bp_st_wen", 32'(ram_wen), 32'hF);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("bp_st_valid", 32'(rsp_valid), 32'd1);
    chk("bp_st_rdata", rsp_rdata, 32'd0);
    chk("bp_st_err", 32'(rsp_err), 32'd0);
    repeat (2) @(negedge clk);
    chk("bp_wen_once", 32'(wen_pulses - p0), 32'd1);
    exp_pulses++;
    for (int i = 0; i < 4; i++) ref_mem[32'h30 + i] = req_wdata[8*i +: 8];

    // Reset while in RD_WAIT
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2;
    req_addr = 32'h30; rsp_ready = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rw_rst_valid", 32'(rsp_valid), 32'd0);
    chk("rw_rst_ready", 32'(req_ready), 32'd0);
    chk("rw_rst_ren", 32'(ram_ren), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rw_rst_hold", 32'(rsp_valid), 32'd0);
    end
    @(negedge clk); rst_n = 1'b1; req_valid = 1'b0;
    @(negedge clk); #1;
    chk("rw_post_valid", 32'(rsp_valid), 32'd0);
    chk("rw_post_idle", 32'(req_ready), 32'd1);
    apply(model(0, 2, 0, 32'h30, 0));

    // Random traffic against the reference model
    for (int n = 0; n < 200; n++) begin
      sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a = ($urandom_range(0, 15) == 0) ? $urandom : 32'($urandom_range(0, 63));
      if ($urandom_range(0, 3) != 0 && sz != 2'd3)
        a = a & ~((32'd1 << sz) - 32'd1);
      v = model(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                a, $urandom);
      apply(v);
    end

    @(negedge clk); req_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("wen_pulse_total", 32'(wen_pulses), 32'(exp_pulses));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
